// File: rtl/alu_pkg.sv
// Shared widths and the command record that the issue queue buffers for the ALU.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;
  localparam int ALU_NUM_W  = 5;
  localparam int ALU_WIDTH  = 32;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] ctrl;
    logic [ALU_NUM_W-1:0]  num;
    logic [ALU_WIDTH-1:0]  a;
    logic [ALU_WIDTH-1:0]  b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands; the head entry is read straight from registered storage.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  alu_cmd_t      wr_data,
  input  logic          rd_en,
  output alu_cmd_t      rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            wr_fire;
  logic            rd_fire;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Full blocks a push even when a pop happens on the same edge: no pass-through.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Command queue feeding a combinational ALU plus a registered, handshaked result port.
// Optional statistics counters are built when ALU_ISSUE_STATS_EN is defined.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int WIDTH  = ALU_WIDTH,
  parameter  int CTRL_W = ALU_CTRL_W,
  parameter  int NUM_W  = ALU_NUM_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [NUM_W-1:0]  IN_NUM,
  input  logic [WIDTH-1:0]  IN_A,
  input  logic [WIDTH-1:0]  IN_B,
  output logic [CTRL_W-1:0] CTRL,
  output logic [NUM_W-1:0]  NUM,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  input  logic [WIDTH-1:0]  Y,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  OUT_Y,
`ifdef ALU_ISSUE_STATS_EN
  output logic [15:0]       ISSUE_CNT,
  output logic [15:0]       STALL_CNT,
`endif
  output logic [CNT_W-1:0]  COUNT
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // valid producer holds its payload until that edge, ready never depends on valid.

  alu_cmd_t wr_cmd;
  alu_cmd_t head;
  logic     full;
  logic     empty;
  logic     fire;

  // Widths below must match alu_pkg; parameters exist for port sizing only.
  assign wr_cmd = '{ctrl: IN_CTRL, num: IN_NUM, a: IN_A, b: IN_B};

  assign IN_READY = !full;
  assign fire     = !empty && (!OUT_VALID || OUT_READY);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (IN_VALID),
    .wr_data (wr_cmd),
    .rd_en   (fire),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (COUNT)
  );

  assign CTRL = head.ctrl;
  assign NUM  = head.num;
  assign A    = head.a;
  assign B    = head.b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_Y     <= '0;
    end else if (fire) begin
      OUT_VALID <= 1'b1;
      OUT_Y     <= Y;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ISSUE_CNT <= '0;
      STALL_CNT <= '0;
    end else begin
      if (fire && ISSUE_CNT != 16'hFFFF) ISSUE_CNT <= ISSUE_CNT + 16'd1;
      if (IN_VALID && !IN_READY && STALL_CNT != 16'hFFFF) STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: vector table plus fill, stream and reset sequences.
module tb_alu_issue_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [4:0]  in_num;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  ctrl;
  logic [4:0]  num;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [2:0]  count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;
`endif

  int n_checks;
  int n_fail;
  int results_seen;
  logic [31:0] exp_q[$];

  alu_issue_queue #(.DEPTH(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_CTRL   (in_ctrl),
    .IN_NUM    (in_num),
    .IN_A      (in_a),
    .IN_B      (in_b),
    .CTRL      (ctrl),
    .NUM       (num),
    .A         (a),
    .B         (b),
    .Y         (y),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_Y     (out_y),
`ifdef ALU_ISSUE_STATS_EN
    .ISSUE_CNT (issue_cnt),
    .STALL_CNT (stall_cnt),
`endif
    .COUNT     (count)
  );

  // Stand-in combinational ALU driven from the queue head.
  function automatic logic [31:0] alu_model(logic [2:0] c, logic [4:0] n,
                                            logic [31:0] x, logic [31:0] z);
    case (c)
      3'd0:    return x + z;
      3'd1:    return x - z;
      3'd2:    return x & z;
      3'd3:    return x | z;
      3'd4:    return x ^ z;
      3'd5:    return x << n;
      3'd6:    return x >> n;
      default: return ~x;
    endcase
  endfunction

  assign y = alu_model(ctrl, num, a, b);

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(logic v, logic [2:0] c, logic [4:0] n, logic [31:0] x, logic [31:0] z);
    in_valid = v;
    in_ctrl  = c;
    in_num   = n;
    in_a     = x;
    in_b     = z;
  endtask

  // Scoreboard: expected results enqueued on accepted pushes, checked on consumption.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_y, 32'hDEAD_BEEF);
        end else begin
          check("result_order", out_y, exp_q.pop_front());
        end
        results_seen++;
      end
      if (in_valid && in_ready) exp_q.push_back(alu_model(in_ctrl, in_num, in_a, in_b));
    end
  end

  typedef struct {
    logic        iv;
    logic [2:0]  c;
    logic [4:0]  n;
    logic [31:0] x;
    logic [31:0] z;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_y;
    logic [2:0]  e_count;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int seen0;
    int idx;
    logic acc;

    n_checks = 0;
    n_fail = 0;
    results_seen = 0;
    out_ready = 1'b1;
    drive_cmd(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);

    // Each record: inputs for one cycle, expected state after that edge.
    vecs[0] = '{1'b1, 3'd0, 5'd5, 32'd30,  32'd90, 1'b1, 1'b1, 1'b0, 32'd0,   3'd1, 32'd30,  32'd90};
    vecs[1] = '{1'b0, 3'd0, 5'd0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b1, 32'd120, 3'd0, 32'd0,   32'd0};
    vecs[2] = '{1'b0, 3'd0, 5'd0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b0, 32'd120, 3'd0, 32'd0,   32'd0};
    vecs[3] = '{1'b1, 3'd1, 5'd0, 32'd100, 32'd1,  1'b1, 1'b1, 1'b0, 32'd120, 3'd1, 32'd100, 32'd1};
    vecs[4] = '{1'b1, 3'd5, 5'd4, 32'd3,   32'd0,  1'b1, 1'b1, 1'b1, 32'd99,  3'd1, 32'd3,   32'd0};
    vecs[5] = '{1'b0, 3'd0, 5'd0, 32'd0,   32'd0,  1'b0, 1'b1, 1'b1, 32'd99,  3'd1, 32'd3,   32'd0};
    vecs[6] = '{1'b0, 3'd0, 5'd0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b1, 32'd48,  3'd0, 32'd0,   32'd0};
    vecs[7] = '{1'b0, 3'd0, 5'd0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b0, 32'd48,  3'd0, 32'd0,   32'd0};

    // Reset state
    do_reset(2);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y",     out_y,              32'd0);
    check("rst_count",     {29'd0, count},     32'd0);
    check("rst_a",         a,                  32'd0);
    check("rst_b",         b,                  32'd0);

    // Single command and short sequences from the table
    for (int i = 0; i < 8; i++) begin
      drive_cmd(vecs[i].iv, vecs[i].c, vecs[i].n, vecs[i].x, vecs[i].z);
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_irdy});
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      check($sformatf("vec%0d_out_y", i),     out_y,              vecs[i].e_y);
      check($sformatf("vec%0d_count", i),     {29'd0, count},     {29'd0, vecs[i].e_count});
      check($sformatf("vec%0d_a", i),         a,                  vecs[i].e_a);
      check($sformatf("vec%0d_b", i),         b,                  vecs[i].e_b);
    end
    drive_cmd(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);

    // Fill and backpressure: 8 offers, 5 accepted, last 3 stalled
    do_reset(1);
    out_ready = 1'b0;
    seen0 = results_seen;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      drive_cmd(1'b1, 3'(idx), 5'(idx + 1), 32'h100 + 32'(idx * 7), 32'h20 + 32'(idx));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    check("fill_accepted",  32'(idx),           32'd5);
    check("fill_count",     {29'd0, count},     32'd4);
    check("fill_in_ready",  {31'd0, in_ready},  32'd0);
    check("fill_out_valid", {31'd0, out_valid}, 32'd1);
    check("fill_out_y",     out_y,              alu_model(3'd0, 5'd1, 32'h100, 32'h20));
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_one_per_cycle", 32'(results_seen - seen0), 32'd5);
    check("drain_out_valid",     {31'd0, out_valid},        32'd0);
    for (int k = 5; k < 8; k++) begin
      drive_cmd(1'b1, 3'(k), 5'(k + 1), 32'h100 + 32'(k * 7), 32'h20 + 32'(k));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("fill_total_results", 32'(results_seen - seen0), 32'd8);
    check("fill_queue_empty",   32'(exp_q.size()),         32'd0);
`ifdef ALU_ISSUE_STATS_EN
    check("stats_issue_cnt", {16'd0, issue_cnt}, 32'd8);
    check("stats_stall_cnt", {16'd0, stall_cnt}, 32'd3);
`endif

    // Streaming with pointer wrap
    do_reset(1);
    out_ready = 1'b1;
    seen0 = results_seen;
    for (int k = 0; k < 20; k++) begin
      drive_cmd(1'b1, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom);
      @(posedge clk);
      #1;
      check("stream_count_le1", {31'd0, (count <= 3'd1)}, 32'd1);
      check("stream_in_ready",  {31'd0, in_ready},        32'd1);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stream_results", 32'(results_seen - seen0), 32'd20);
    check("stream_empty",   32'(exp_q.size()),         32'd0);

    // Reset mid-operation: 3 queued plus one held result
    do_reset(1);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_cmd(1'b1, 3'd4, 5'd0, 32'hA5A5_0000 + 32'(k), 32'h0F0F_0F0F);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("mid_count_before", {29'd0, count},     32'd3);
    check("mid_ov_before",    {31'd0, out_valid}, 32'd1);
    do_reset(1);
    check("mid_count_after", {29'd0, count},     32'd0);
    check("mid_ov_after",    {31'd0, out_valid}, 32'd0);
    check("mid_out_y_after", out_y,              32'd0);
    check("mid_a_after",     a,                  32'd0);
    out_ready = 1'b1;
    seen0 = results_seen;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end
    check("mid_no_results", 32'(results_seen - seen0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Command buffer and result register directly upstream and downstream of the combinational ALU (CTRL[2:0], NUM[4:0], A[31:0], B[31:0] -> Y[31:0]).
- Accepts ALU commands on a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- The FIFO head drives the ALU operand ports from registers; the ALU's Y is captured into a registered result port with its own valid/ready handshake.
- The block is opcode-agnostic: CTRL and NUM pass through untouched.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- WIDTH, 32, operand and result width.
- CTRL_W, 3, ALU control width.
- NUM_W, 5, shift-amount width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  command present.
- IN_READY  out  1  queue can accept a command.
- IN_CTRL  in  CTRL_W  command ALU control.
- IN_NUM  in  NUM_W  command shift amount.
- IN_A  in  WIDTH  command operand A.
- IN_B  in  WIDTH  command operand B.
- CTRL  out  CTRL_W  to ALU: head entry control.
- NUM  out  NUM_W  to ALU: head entry shift amount.
- A  out  WIDTH  to ALU: head entry operand A.
- B  out  WIDTH  to ALU: head entry operand B.
- Y  in  WIDTH  from ALU: combinational result.
- OUT_VALID  out  1  OUT_Y holds an unconsumed result.
- OUT_READY  in  1  consumer accepts the result.
- OUT_Y  out  WIDTH  registered ALU result.
- COUNT  out  clog2(DEPTH)+1  FIFO occupancy, excluding the result register.

Behaviour:
- Reset: all FIFO storage, pointers, COUNT, OUT_VALID and OUT_Y cleared to 0. CTRL/NUM/A/B therefore read 0. IN_READY=1 from the first cycle after reset.
- Reset mid-operation discards every queued command and any pending result; nothing is emitted afterwards.
- Push: on an edge with IN_VALID && IN_READY, the command is written at wr_ptr and wr_ptr increments mod DEPTH.
- IN_READY = (COUNT != DEPTH). A pop in the same cycle does not free space for a push when full; there is no pass-through.
- ALU ports: CTRL/NUM/A/B = storage[rd_ptr], always.
  - When empty, they show the stale entry at rd_ptr, which is harmless because no capture occurs.
- Pop/capture: fire = (COUNT != 0) && (!OUT_VALID || OUT_READY). On fire, OUT_Y <= Y, OUT_VALID <= 1, and rd_ptr increments mod DEPTH.
- If OUT_VALID && OUT_READY && COUNT==0: OUT_VALID <= 0 and OUT_Y holds its last value.
- Push and pop in the same edge: COUNT unchanged; both pointers advance.
- Latency: a command pushed at edge N appears on the ALU ports after edge N and yields OUT_VALID after edge N+1. Minimum latency is 2 cycles; sustained throughput is 1 per cycle.
- No bypass when the queue is empty.
- Ordering: results are strictly in push order.
- Pointers wrap modulo DEPTH. COUNT never exceeds DEPTH or underflows.
- Total commands in flight is at most DEPTH+1 (FIFO plus result register).

Optional Feature:
ALU_ISSUE_STATS_EN
- Defined: adds two outputs.
  - ISSUE_CNT[15:0]: increments on each fire.
  - STALL_CNT[15:0]: increments each cycle with IN_VALID && !IN_READY.
  - Both saturate at 16'hFFFF and clear on RST.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - Constants ALU_CTRL_W=3, ALU_NUM_W=5, ALU_WIDTH=32.
  - Packed typedef alu_cmd_t {ctrl, num, a, b}. The FIFO stores alu_cmd_t.
- Sub-module alu_cmd_fifo: generic synchronous FIFO with wr_en/rd_en, full/empty/count, and a registered-storage head read.
- The top level adds the result register, fire logic and the optional statistics counters.

Test Plan:
1. Reset check: RST high 2 cycles -> IN_READY=1, OUT_VALID=0, OUT_Y=0, COUNT=0, A=B=0.
2. Single command: push CTRL=3'b000, NUM=5, A=30, B=90 at edge N with OUT_READY=1 -> A=30/B=90 on the ALU ports after N; OUT_VALID=1 and OUT_Y=golden ALU(000,5,30,90) after N+1; OUT_VALID=0 after N+2.
3. Fill and backpressure: OUT_READY=0, offer CTRL=000..111 back-to-back -> exactly 5 accepted, IN_READY=0 with COUNT=4, OUT_Y=result of CTRL 000. Then OUT_READY=1 -> results drain in order, one per cycle, with no loss or duplication.
4. Streaming with wrap: 20 random commands, IN_VALID and OUT_READY both held 1 -> one result per cycle after 2-cycle latency; pointers wrap 5 times; COUNT stays <= 1.
5. Reset mid-operation: 3 commands queued and OUT_VALID=1, assert RST one cycle -> COUNT=0 and OUT_VALID=0 next cycle; no stale result ever appears.
6. With ALU_ISSUE_STATS_EN defined, run scenario 3 -> ISSUE_CNT=8 after drain; STALL_CNT equals the number of cycles IN_VALID was high while IN_READY=0 (3 with back-to-back offers).
